ctrl_seq: RTL

//  Sequenced control unit for the 9-bit ISA: decodes the current instruction and drives PC advance, branch,

---
 rtl/ctrl_seq_if.sv | 29 ++
 rtl/ctrl_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_if.sv
// Control-unit bus: run/halt command, fetched instruction and branch operand in,
// PC/register/memory strobes out. The master side is the fetch/datapath, the slave side is ctrl_seq.
interface ctrl_seq_if #(
    parameter int INSTR_W = 9,
    parameter int DATA_W  = 8
);
    logic               Start;
    logic [INSTR_W-1:0] Instruction;
    logic [DATA_W-1:0]  JmpReg;
    logic               PcEn;
    logic               Jump;
    logic               BranchEn;
    logic               RegWrEn;
    logic               MemRdEn;
    logic               MemWrEn;
    logic               Stall;
    logic               Flush;
    logic               Halted;

    modport master (
        output Start, Instruction, JmpReg,
        input  PcEn, Jump, BranchEn, RegWrEn, MemRdEn, MemWrEn, Stall, Flush, Halted
    );

    modport slave (
        input  Start, Instruction, JmpReg,
        output PcEn, Jump, BranchEn, RegWrEn, MemRdEn, MemWrEn, Stall, Flush, Halted
    );
endinterface

// File: rtl/ctrl_seq.sv
// Sequenced control unit for the 9-bit ISA: run/halt sequencing, multi-cycle load stalls, conditional branches.
// Optional CTRL_FLUSH_EN annuls the instruction fetched behind a taken branch.
module ctrl_seq #(
    parameter int INSTR_W = 9,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input logic          Clk,
    input logic          Reset,
    ctrl_seq_if.slave    bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_LDWAIT = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LD   = 4'b1000;
    localparam logic [3:0] OP_ST   = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_JMPU = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] opcode;
    logic       cond_met;
    logic       pc_en, jump, branch_en, reg_wr_en, mem_rd_en, mem_wr_en, stall, flush;

    // Bits between the opcode and the condition field belong to the datapath, not to control.
    logic unused_operand;
    assign unused_operand = ^bus.Instruction[INSTR_W-5:2];

    assign opcode = bus.Instruction[INSTR_W-1 -: 4];

    always_comb begin
        cond_met = 1'b0;
        case (bus.Instruction[1:0])
            2'b00:   cond_met = (bus.JmpReg == DATA_W'(1));
            2'b01:   cond_met = (bus.JmpReg == '0);
            2'b10:   cond_met = (bus.JmpReg != '0);
            default: cond_met = bus.JmpReg[DATA_W-1];
        endcase
    end

`ifdef CTRL_FLUSH_EN
    logic flush_q, flush_d;
`endif

    // NOTE: every output and next-state signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_en     = 1'b0;
        jump      = 1'b0;
        branch_en = 1'b0;
        reg_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
`ifdef CTRL_FLUSH_EN
        flush_d   = 1'b0;
`endif

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.Start) state_d = S_RUN;
            end

            S_RUN: begin
                case (opcode)
                    OP_NOP:  pc_en = 1'b1;
                    OP_ST:   begin mem_wr_en = 1'b1; pc_en = 1'b1; end
                    OP_JMPU: begin jump = 1'b1; branch_en = 1'b1; pc_en = 1'b1; end
                    OP_JMP:  begin jump = 1'b1; branch_en = cond_met; pc_en = 1'b1; end
                    OP_HALT: state_d = S_HALT;
                    OP_LD: begin
                        mem_rd_en = 1'b1;
                        if (MEM_LAT == 1) begin
                            reg_wr_en = 1'b1;
                            pc_en     = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = CNT_INIT;
                            state_d = S_LDWAIT;
                        end
                    end
                    default: begin reg_wr_en = 1'b1; pc_en = 1'b1; end
                endcase
`ifdef CTRL_FLUSH_EN
                // The slot behind a taken branch still advances the PC but has no side effects.
                if (flush_q) begin
                    jump      = 1'b0;
                    branch_en = 1'b0;
                    reg_wr_en = 1'b0;
                    mem_rd_en = 1'b0;
                    mem_wr_en = 1'b0;
                    stall     = 1'b0;
                    flush     = 1'b1;
                    pc_en     = 1'b1;
                    cnt_d     = cnt_q;
                    state_d   = S_RUN;
                end
                flush_d = branch_en;
`endif
            end

            S_LDWAIT: begin
                mem_rd_en = 1'b1;
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    reg_wr_en = 1'b1;
                    pc_en     = 1'b1;
                    state_d   = S_RUN;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CTRL_FLUSH_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) flush_q <= 1'b0;
        else        flush_q <= flush_d;
    end
`endif

    assign bus.PcEn     = pc_en;
    assign bus.Jump     = jump;
    assign bus.BranchEn = branch_en;
    assign bus.RegWrEn  = reg_wr_en;
    assign bus.MemRdEn  = mem_rd_en;
    assign bus.MemWrEn  = mem_wr_en;
    assign bus.Stall    = stall;
    assign bus.Flush    = flush;
    assign bus.Halted   = (state_q == S_HALT);

endmodule
